// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package keypad_scan_pkg;

  localparam int KEY_W    = 5;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Classification of the synchronized (active-low) column lines on one tick.
  typedef enum logic [1:0] {
    PAT_NONE  = 2'd0,
    PAT_ONE   = 2'd1,
    PAT_MULTI = 2'd2
  } col_pat_t;

  function automatic col_pat_t col_pattern(input logic [NUM_COLS-1:0] colsync);
    int lows;
    lows = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!colsync[i]) lows++;
    end
    if (lows == 0)      col_pattern = PAT_NONE;
    else if (lows == 1) col_pattern = PAT_ONE;
    else                col_pattern = PAT_MULTI;
  endfunction

  // Index of the lowest-numbered low column; only meaningful for PAT_ONE.
  function automatic logic [1:0] low_col(input logic [NUM_COLS-1:0] colsync);
    low_col = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!colsync[i]) low_col = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running prescaler: one-clk tick every DIV clk cycles (count 0..DIV-1).
// Latency: first tick DIV clk after reset release; tick is combinational from the count.
// Backpressure: none, never stalls.
// Ports: clk, rst (sync, active-high), tick (high while count == DIV-1).
module keypad_scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce, one key code per press.
// Latency: a press is accepted DEBOUNCE_TICKS scan ticks after its row is first sampled.
// Backpressure: none; key_valid is a single-cycle pulse with no ready.
// Ports: clk, rst (sync, active-high); COL0..3 in (active-low, async);
//        ROW0..3 out (active-low strobes); key[4:0] = row*4+col; key_valid pulse; key_held level.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             COL0,
  input  logic             COL1,
  input  logic             COL2,
  input  logic             COL3,
  output logic             ROW0,
  output logic             ROW1,
  output logic             ROW2,
  output logic             ROW3,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_DONE = DW'(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic                tick;
  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] colsync;

  state_t              state, state_nx;
  logic [1:0]          row_idx, row_nx;
  logic [DW-1:0]       deb_cnt, deb_nx, deb_inc;
  logic [3:0]          cand, cand_nx;
  logic [3:0]          code;
  logic [KEY_W-1:0]    key_nx;
  logic                held_nx, valid_nx;
  col_pat_t            pat;

  keypad_scan_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; reset to "no key" so nothing is seen right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      colsync  <= '1;
    end else begin
      col_meta <= {COL3, COL2, COL1, COL0};
      colsync  <= col_meta;
    end
  end

  assign ROW0 = (row_idx != 2'd0);
  assign ROW1 = (row_idx != 2'd1);
  assign ROW2 = (row_idx != 2'd2);
  assign ROW3 = (row_idx != 2'd3);

  assign pat     = col_pattern(colsync);
  assign code    = {row_idx, low_col(colsync)};
  assign deb_inc = deb_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    row_nx   = row_idx;
    deb_nx   = deb_cnt;
    cand_nx  = cand;
    key_nx   = key;
    held_nx  = key_held;
    valid_nx = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (pat == PAT_ONE) begin
            cand_nx = code;
            deb_nx  = DEB_ONE;
            // With a single-sample debounce the first sighting is the acceptance.
            if (DEBOUNCE_TICKS == 1) begin
              state_nx = PRESSED;
              key_nx   = {{(KEY_W-4){1'b0}}, code};
              held_nx  = 1'b1;
              valid_nx = 1'b1;
            end else begin
              state_nx = DEBOUNCE;
            end
          end else begin
            row_nx = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (pat == PAT_ONE && code == cand) begin
            deb_nx = deb_inc;
            if (deb_inc == DEB_DONE) begin
              state_nx = PRESSED;
              key_nx   = {{(KEY_W-4){1'b0}}, cand};
              held_nx  = 1'b1;
              valid_nx = 1'b1;
            end
          end else begin
            deb_nx   = '0;
            row_nx   = row_idx + 2'd1;
            state_nx = SCAN;
          end
        end
        PRESSED: begin
          // Row stays put; extra keys on this row are ignored until release.
          if (pat == PAT_NONE) begin
            if (DEBOUNCE_TICKS == 1) begin
              deb_nx   = '0;
              held_nx  = 1'b0;
              row_nx   = row_idx + 2'd1;
              state_nx = SCAN;
            end else begin
              deb_nx   = DEB_ONE;
              state_nx = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (pat == PAT_NONE) begin
            deb_nx = deb_inc;
            if (deb_inc == DEB_DONE) begin
              held_nx  = 1'b0;
              row_nx   = row_idx + 2'd1;
              state_nx = SCAN;
            end
          end else begin
            deb_nx   = '0;
            state_nx = PRESSED;
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      cand      <= '0;
      key       <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      row_idx   <= row_nx;
      deb_cnt   <= deb_nx;
      cand      <= cand_nx;
      key       <= key_nx;
      key_held  <= held_nx;
      key_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int CLK_DIV = 4;
  localparam int DT      = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       COL0, COL1, COL2, COL3;
  logic       ROW0, ROW1, ROW2, ROW3;
  logic [4:0] key;
  logic       key_valid, key_held;

  always #5 clk = ~clk;

  keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .rst(rst),
    .COL0(COL0), .COL1(COL1), .COL2(COL2), .COL3(COL3),
    .ROW0(ROW0), .ROW1(ROW1), .ROW2(ROW2), .ROW3(ROW3),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  // Physical keypad: bit r*4+c of mask closes the switch between row r and column c.
  logic [15:0] mask = 16'h0000;
  logic [3:0]  row_v, col_v;
  assign row_v = {ROW3, ROW2, ROW1, ROW0};
  always_comb begin
    col_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_v[r] && mask[r*4+c]) col_v[c] = 1'b0;
  end
  assign COL0 = col_v[0];
  assign COL1 = col_v[1];
  assign COL2 = col_v[2];
  assign COL3 = col_v[3];

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: scanner behaviour stated as "how many agreeing tick samples so far".
  localparam int M_IDLE = 0, M_CONFIRM = 1, M_HOLD = 2, M_RELCONF = 3;
  int         m_age = 0, m_row = 0, m_mode = M_IDLE, m_run = 0, m_cand = 0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  logic [4:0] m_key = 5'd0;
  logic       m_valid = 1'b0, m_held = 1'b0;

  task automatic model_step(input logic r, input logic [3:0] raw);
    logic [3:0] lows;
    int n, c, code;
    if (r) begin
      m_age = 0; m_row = 0; m_mode = M_IDLE; m_run = 0; m_cand = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_key = 5'd0; m_valid = 1'b0; m_held = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if ((m_age % CLK_DIV) == CLK_DIV - 1) begin
      lows = ~m_s2;
      n = $countones(lows);
      c = 0;
      for (int i = 3; i >= 0; i--) if (lows[i]) c = i;
      code = m_row * 4 + c;
      case (m_mode)
        M_IDLE:
          if (n == 1) begin
            m_cand = code; m_run = 1; m_mode = M_CONFIRM;
          end else m_row = (m_row + 1) % 4;
        M_CONFIRM:
          if (n == 1 && code == m_cand) m_run++;
          else begin m_run = 0; m_mode = M_IDLE; m_row = (m_row + 1) % 4; end
        M_HOLD:
          if (n == 0) begin m_run = 1; m_mode = M_RELCONF; end
        default:
          if (n == 0) m_run++;
          else begin m_run = 0; m_mode = M_HOLD; end
      endcase
      if (m_mode == M_CONFIRM && m_run >= DT) begin
        m_key = 5'(m_cand); m_held = 1'b1; m_valid = 1'b1; m_mode = M_HOLD;
      end
      if (m_mode == M_RELCONF && m_run >= DT) begin
        m_held = 1'b0; m_row = (m_row + 1) % 4; m_mode = M_IDLE;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_age++;
  endtask

  // One clock: capture inputs mid-cycle, step model on the edge, compare 1 time unit later.
  task automatic cyc();
    logic       r;
    logic [3:0] raw, er, one;
    @(negedge clk);
    r = rst;
    raw = col_v;
    @(posedge clk);
    #1;
    model_step(r, raw);
    one = 4'b0001;
    er = ~(one << m_row);
    if (key_valid === 1'b1) pulses++;
    check("model", {21'd0, row_v, key, key_valid, key_held},
                   {21'd0, er, m_key, m_valid, m_held});
  endtask

  typedef struct {
    logic [15:0] mask;
    int          hold;
    int          exp_pulses;
    logic [4:0]  exp_key;
  } vec_t;

  vec_t       vecs[5];
  int         lat, cnt;
  bit         found;
  logic [3:0] seen, one4;

  initial begin
    vecs[0] = '{16'h0001, 150, 1, 5'd0};
    vecs[1] = '{16'h8000, 150, 1, 5'd15};
    vecs[2] = '{16'h0040, 150, 1, 5'd6};
    vecs[3] = '{16'h0090, 100, 0, 5'd6};   // keys 4 and 7 share row 1: MULTI
    vecs[4] = '{16'h0000,  40, 0, 5'd6};

    // 1. reset
    rst = 1'b1;
    cyc(); cyc();
    check("rst_row", {28'd0, row_v}, 32'hE);
    check("rst_key", {27'd0, key}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
    rst = 1'b0;

    // 2. idle rotation: after k edges out of reset the low row is (k/4)%4
    one4 = 4'b0001;
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (row_v !== ~(one4 << ((k / 4) % 4))) cnt++;
    end
    check("rotate_errs", cnt, 0);
    check("idle_pulses", pulses, 0);

    // 3. press row2/col1 just as row 2 becomes active, hold, release
    pulses = 0;
    mask = 16'h0200;
    found = 0; lat = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(); lat++;
      if (key_valid === 1'b1) found = 1;
    end
    check("press_seen", found, 1);
    check("press_lat", lat, 12);
    check("press_key", key, 9);
    check("press_held", key_held, 1);
    cnt = 0;
    repeat (200) begin
      cyc();
      if (row_v !== 4'b1011) cnt++;
    end
    check("held_row_errs", cnt, 0);
    check("one_pulse", pulses, 1);
    mask = 16'h0000;
    found = 0; lat = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(); lat++;
      if (key_held === 1'b0) found = 1;
    end
    check("release_seen", found, 1);
    check("release_lat_ok", (lat >= 11 && lat <= 14), 1);
    check("release_row3", row_v, 4'b0111);
    check("release_key", key, 9);

    // 4. bounce: key visible for one tick sample on row 2
    pulses = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (row_v === 4'b1011) found = 1;
    end
    check("bounce_row2", found, 1);
    mask = 16'h0200;
    repeat (4) cyc();
    mask = 16'h0000;
    seen = 4'h0;
    repeat (24) begin
      cyc();
      seen = seen | ~row_v;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_key", key, 9);
    check("bounce_rows", seen, 4'hF);

    // 5. two columns low on row 1
    pulses = 0;
    mask = 16'h0090;
    seen = 4'h0;
    repeat (60) begin
      cyc();
      seen = seen | ~row_v;
    end
    mask = 16'h0000;
    check("multi_pulses", pulses, 0);
    check("multi_rows", seen, 4'hF);
    check("multi_held", key_held, 0);

    // 6. reset while pressed, then re-detect
    mask = 16'h0200;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (key_held === 1'b1) found = 1;
    end
    check("pre_rst_held", found, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_row", row_v, 4'b1110);
    check("abort_key", key, 0);
    check("abort_held", key_held, 0);
    check("abort_valid", key_valid, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (key_valid === 1'b1) found = 1;
    end
    check("redetect", found, 1);
    check("redetect_key", key, 9);
    mask = 16'h0000;
    repeat (40) cyc();

    // table-driven presses
    for (int v = 0; v < 5; v++) begin
      pulses = 0;
      mask = vecs[v].mask;
      repeat (vecs[v].hold) cyc();
      mask = 16'h0000;
      repeat (40) cyc();
      check("vec_pulses", pulses, vecs[v].exp_pulses);
      check("vec_key", key, vecs[v].exp_key);
      check("vec_held", key_held, 0);
    end

    // randomized presses, chords, gaps and resets against the model
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)      mask = 16'h0001 << $urandom_range(0, 15);
      else if (sel < 8) mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      else              mask = 16'h0000;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 80)) cyc();
    end
    mask = 16'h0000;
    repeat (40) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
